// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM states, op codes,
// default timeout and the counter width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int TIMEOUT_DEFAULT = 40;

  // Bits needed to hold values 0..max_count inclusive (never less than one).
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end else begin
      return $clog2(max_count + 1);
    end
  endfunction

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Saturating cycle counter used to bound the wait for the datapath.
module muldiv_cycle_counter
  import muldiv_pkg::*;
#(
  parameter int MAX = TIMEOUT_DEFAULT,
  parameter int CW  = cnt_width(MAX)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX);

  logic [CW-1:0] count_r;

  // Count enabled cycles; clear wins over enable, and the value sticks at MAX.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable && (count_r != COUNT_MAX)) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/muldiv_sequencer.sv
// Issue/writeback sequencer wrapping an external multi-cycle multiply/divide
// datapath: accepts one request at a time, pulses the datapath, waits for
// completion (bounded), and holds the result until the consumer accepts it.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int W       = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [4:0]   req_rd,
  output logic         req_ready,
  input  logic         flush,
  output logic [W-1:0] dp_A,
  output logic [W-1:0] dp_B,
  output logic         dp_ctrl_MULT,
  output logic         dp_ctrl_DIV,
  input  logic [W-1:0] dp_result,
  input  logic         dp_exception,
  input  logic         dp_ready,
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [W-1:0] wb_data,
  output logic         wb_exception,
  input  logic         wb_accept,
  output logic         stall
);

  localparam int            CW       = cnt_width(TIMEOUT);
  // The counter reads LAST_RUN during the TIMEOUT-th RUN cycle.
  localparam logic [CW-1:0] LAST_RUN = CW'(TIMEOUT - 1);

  state_t         state_r, state_n;
  logic [4:0]     rd_r, rd_n;
  logic [W-1:0]   dp_a_r, dp_a_n, dp_b_r, dp_b_n;
  logic           mult_r, mult_n, div_r, div_n;
  logic [W-1:0]   wb_data_r, wb_data_n;
  logic           wb_exc_r, wb_exc_n;
  logic           wb_valid_r, wb_rd_sel_s;
  logic [4:0]     wb_rd_r;
  logic           req_ready_r, stall_r;
  logic           cnt_clear_s, cnt_enable_s;
  logic [CW-1:0]  cnt_s;

  muldiv_cycle_counter #(.MAX(TIMEOUT), .CW(CW)) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear_s),
    .enable (cnt_enable_s),
    .count  (cnt_s)
  );

  // Next-state and next-output decode; flush overrides everything but reset.
  always_comb begin
    state_n      = state_r;
    rd_n         = rd_r;
    dp_a_n       = dp_a_r;
    dp_b_n       = dp_b_r;
    mult_n       = 1'b0;
    div_n        = 1'b0;
    wb_data_n    = wb_data_r;
    wb_exc_n     = wb_exc_r;
    cnt_clear_s  = 1'b0;
    cnt_enable_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        dp_a_n    = {W{1'b0}};
        dp_b_n    = {W{1'b0}};
        wb_data_n = {W{1'b0}};
        wb_exc_n  = 1'b0;
        if (req_valid) begin
          rd_n = req_rd;
          if ((req_op == OP_DIV) && (req_b == {W{1'b0}})) begin
            // Divide by zero resolves locally without touching the datapath.
            state_n  = ST_DONE;
            wb_exc_n = 1'b1;
          end else begin
            state_n = ST_START;
            dp_a_n  = req_a;
            dp_b_n  = req_b;
            mult_n  = (req_op == OP_MULT);
            div_n   = (req_op == OP_DIV);
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_clear_s = 1'b1;
        state_n     = ST_RUN;
      end
      ST_RUN: begin
        cnt_enable_s = 1'b1;
        if (dp_ready) begin
          state_n   = ST_DONE;
          wb_data_n = dp_result;
          wb_exc_n  = dp_exception;
          dp_a_n    = {W{1'b0}};
          dp_b_n    = {W{1'b0}};
        end else if (cnt_s == LAST_RUN) begin
          state_n   = ST_DONE;
          wb_data_n = {W{1'b0}};
          wb_exc_n  = 1'b1;
          dp_a_n    = {W{1'b0}};
          dp_b_n    = {W{1'b0}};
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        if (wb_accept) begin
          state_n   = ST_IDLE;
          wb_data_n = {W{1'b0}};
          wb_exc_n  = 1'b0;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        dp_a_n    = {W{1'b0}};
        dp_b_n    = {W{1'b0}};
        wb_data_n = {W{1'b0}};
        wb_exc_n  = 1'b0;
      end
    endcase

    if (flush) begin
      state_n   = ST_IDLE;
      mult_n    = 1'b0;
      div_n     = 1'b0;
      dp_a_n    = {W{1'b0}};
      dp_b_n    = {W{1'b0}};
      wb_data_n = {W{1'b0}};
      wb_exc_n  = 1'b0;
    end else begin
      state_n = state_n;
    end

    wb_rd_sel_s = (state_n == ST_DONE);
  end

  // State and registered-output update; reset abandons any operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rd_r        <= 5'd0;
      dp_a_r      <= {W{1'b0}};
      dp_b_r      <= {W{1'b0}};
      mult_r      <= 1'b0;
      div_r       <= 1'b0;
      wb_data_r   <= {W{1'b0}};
      wb_exc_r    <= 1'b0;
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= 5'd0;
      req_ready_r <= 1'b1;
      stall_r     <= 1'b0;
    end else begin
      state_r     <= state_n;
      rd_r        <= rd_n;
      dp_a_r      <= dp_a_n;
      dp_b_r      <= dp_b_n;
      mult_r      <= mult_n;
      div_r       <= div_n;
      wb_data_r   <= wb_data_n;
      wb_exc_r    <= wb_exc_n;
      wb_valid_r  <= wb_rd_sel_s;
      wb_rd_r     <= wb_rd_sel_s ? rd_n : 5'd0;
      req_ready_r <= (state_n == ST_IDLE);
      stall_r     <= (state_n != ST_IDLE);
    end
  end

  assign req_ready    = req_ready_r;
  assign stall        = stall_r;
  assign dp_A         = dp_a_r;
  assign dp_B         = dp_b_r;
  assign dp_ctrl_MULT = mult_r;
  assign dp_ctrl_DIV  = div_r;
  assign wb_valid     = wb_valid_r;
  assign wb_rd        = wb_rd_r;
  assign wb_data      = wb_data_r;
  assign wb_exception = wb_exc_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (TIMEOUT=40, W=32).
module tb_muldiv_sequencer;

  localparam int W       = 32;
  localparam int TIMEOUT = 40;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [4:0]   req_rd;
  logic         req_ready;
  logic         flush;
  logic [W-1:0] dp_A;
  logic [W-1:0] dp_B;
  logic         dp_ctrl_MULT;
  logic         dp_ctrl_DIV;
  logic [W-1:0] dp_result;
  logic         dp_exception;
  logic         dp_ready;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic         wb_exception;
  logic         wb_accept;
  logic         stall;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.TIMEOUT(TIMEOUT), .W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_rd       (req_rd),
    .req_ready    (req_ready),
    .flush        (flush),
    .dp_A         (dp_A),
    .dp_B         (dp_B),
    .dp_ctrl_MULT (dp_ctrl_MULT),
    .dp_ctrl_DIV  (dp_ctrl_DIV),
    .dp_result    (dp_result),
    .dp_exception (dp_exception),
    .dp_ready     (dp_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_exception (wb_exception),
    .wb_accept    (wb_accept),
    .stall        (stall)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({req_ready, stall, wb_valid, wb_exception, dp_ctrl_MULT, dp_ctrl_DIV} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b want 100000",
               {req_ready, stall, wb_valid, wb_exception, dp_ctrl_MULT, dp_ctrl_DIV});
    end
    checks++;
    if ((wb_data !== 32'd0) || (wb_rd !== 5'd0) || (dp_A !== 32'd0) || (dp_B !== 32'd0)) begin
      errors++;
      $display("FAIL reset_data got wb_data=%h wb_rd=%0d dp_A=%h dp_B=%h want all zero",
               wb_data, wb_rd, dp_A, dp_B);
    end
  endtask

  task automatic test_divide();
    int pulses;
    issue(1'b1, 32'd100, 32'd7, 5'd5);
    // Now in START: exactly one DIV pulse with the operands presented.
    checks++;
    if ({dp_ctrl_DIV, dp_ctrl_MULT, req_ready, stall} !== 4'b1001) begin
      errors++;
      $display("FAIL div_start got div/mult/ready/stall=%b want 1001",
               {dp_ctrl_DIV, dp_ctrl_MULT, req_ready, stall});
    end
    checks++;
    if ((dp_A !== 32'd100) || (dp_B !== 32'd7)) begin
      errors++;
      $display("FAIL div_operands got %0d/%0d want 100/7", dp_A, dp_B);
    end
    pulses = 1;
    for (int i = 1; i < 32; i++) begin
      tick();
      if (dp_ctrl_DIV === 1'b1) pulses++;
    end
    tick();
    // Pulse cycle + 32: datapath completes.
    dp_ready  = 1'b1;
    dp_result = 32'd14;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL div_early_wb got wb_valid=%b want 0", wb_valid);
    end
    tick();
    dp_ready  = 1'b0;
    dp_result = 32'd0;
    checks++;
    if ({wb_valid, wb_exception} !== 2'b10 || wb_data !== 32'd14 || wb_rd !== 5'd5) begin
      errors++;
      $display("FAIL div_result got v=%b e=%b data=%0d rd=%0d want v=1 e=0 data=14 rd=5",
               wb_valid, wb_exception, wb_data, wb_rd);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL div_pulse_count got %0d want 1", pulses);
    end
    // A request while DONE must be ignored.
    issue(1'b0, 32'd1, 32'd1, 5'd1);
    checks++;
    if ({wb_valid, req_ready, dp_ctrl_MULT} !== 3'b100 || wb_data !== 32'd14) begin
      errors++;
      $display("FAIL done_ignores_req got v/ready/mult=%b data=%0d want 100 data=14",
               {wb_valid, req_ready, dp_ctrl_MULT}, wb_data);
    end
    wb_accept = 1'b1;
    tick();
    wb_accept = 1'b0;
    checks++;
    if ({wb_valid, req_ready, stall} !== 3'b010) begin
      errors++;
      $display("FAIL div_accept got v/ready/stall=%b want 010", {wb_valid, req_ready, stall});
    end
  endtask

  task automatic test_div_zero();
    issue(1'b1, 32'd5, 32'd0, 5'd9);
    checks++;
    if ({wb_valid, wb_exception, dp_ctrl_DIV, dp_ctrl_MULT} !== 4'b1100 ||
        wb_data !== 32'd0 || wb_rd !== 5'd9) begin
      errors++;
      $display("FAIL div_zero got v/e/div/mult=%b data=%0d rd=%0d want 1100 data=0 rd=9",
               {wb_valid, wb_exception, dp_ctrl_DIV, dp_ctrl_MULT}, wb_data, wb_rd);
    end
    wb_accept = 1'b1;
    tick();
    wb_accept = 1'b0;
  endtask

  task automatic test_mult_hold();
    issue(1'b0, 32'd3, 32'hFFFF_FFFC, 5'd3);
    checks++;
    if ({dp_ctrl_MULT, dp_ctrl_DIV} !== 2'b10) begin
      errors++;
      $display("FAIL mult_pulse got mult/div=%b want 10", {dp_ctrl_MULT, dp_ctrl_DIV});
    end
    tick();
    dp_ready  = 1'b1;
    dp_result = 32'hFFFF_FFF4;
    tick();
    dp_ready  = 1'b0;
    dp_result = 32'd0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || req_ready !== 1'b0 || wb_data !== 32'hFFFF_FFF4 || wb_rd !== 5'd3) begin
        errors++;
        $display("FAIL mult_hold[%0d] got v=%b ready=%b data=%h rd=%0d want v=1 ready=0 data=fffffff4 rd=3",
                 i, wb_valid, req_ready, wb_data, wb_rd);
      end
      tick();
    end
    // Still held on the sixth cycle, then accept.
    wb_accept = 1'b1;
    tick();
    wb_accept = 1'b0;
    checks++;
    if ({wb_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mult_accept got v/ready=%b want 01", {wb_valid, req_ready});
    end
  endtask

  task automatic test_timeout();
    int early;
    issue(1'b0, 32'd2, 32'd2, 5'd7);
    tick();
    // First RUN cycle; exception must appear TIMEOUT cycles later.
    early = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (wb_valid !== 1'b0) early++;
      tick();
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL timeout_early got %0d early wb_valid cycles want 0", early);
    end
    checks++;
    if ({wb_valid, wb_exception} !== 2'b11 || wb_data !== 32'd0 || wb_rd !== 5'd7) begin
      errors++;
      $display("FAIL timeout_result got v/e=%b data=%0d rd=%0d want 11 data=0 rd=7",
               {wb_valid, wb_exception}, wb_data, wb_rd);
    end
    // Flush beats wb_accept in DONE.
    flush     = 1'b1;
    wb_accept = 1'b1;
    tick();
    flush     = 1'b0;
    wb_accept = 1'b0;
    checks++;
    if ({wb_valid, req_ready, wb_exception} !== 3'b010) begin
      errors++;
      $display("FAIL flush_in_done got v/ready/e=%b want 010", {wb_valid, req_ready, wb_exception});
    end
  endtask

  task automatic test_abort(input logic use_reset);
    int bad;
    issue(1'b1, 32'd100, 32'd7, 5'd4);
    tick();
    tick();
    tick();
    if (use_reset) reset = 1'b1;
    else flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    checks++;
    if ({req_ready, stall, wb_valid} !== 3'b100 || dp_A !== 32'd0) begin
      errors++;
      $display("FAIL abort_%0d got ready/stall/v=%b dp_A=%0d want 100 dp_A=0",
               use_reset, {req_ready, stall, wb_valid}, dp_A);
    end
    dp_ready  = 1'b1;
    dp_result = 32'd14;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      dp_ready = 1'b0;
      if (wb_valid !== 1'b0 || req_ready !== 1'b1 || dp_ctrl_DIV !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL late_ready_%0d got %0d bad cycles want 0", use_reset, bad);
    end
  endtask

  task automatic test_flush_beats_req();
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_a     = 32'd6;
    req_b     = 32'd7;
    req_rd    = 5'd2;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    checks++;
    if ({req_ready, stall, dp_ctrl_MULT} !== 3'b100) begin
      errors++;
      $display("FAIL flush_beats_req got ready/stall/mult=%b want 100",
               {req_ready, stall, dp_ctrl_MULT});
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_op       = 1'b0;
    req_a        = 32'd0;
    req_b        = 32'd0;
    req_rd       = 5'd0;
    flush        = 1'b0;
    dp_result    = 32'd0;
    dp_exception = 1'b0;
    dp_ready     = 1'b0;
    wb_accept    = 1'b0;
    #1;
    test_reset();
    test_divide();
    test_div_zero();
    test_mult_hold();
    test_timeout();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_beats_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 40: max cycles to wait for dp_ready after a start pulse.
REQ-002 Parameter W, default 32: operand/result width.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  issue request from pipeline.
REQ-006 req_op  in  1  0 = multiply, 1 = divide.
REQ-007 req_a / req_b  in  W  operand A (dividend/multiplicand), operand B (divisor/multiplier).
REQ-008 req_rd  in  5  destination register tag.
REQ-009 req_ready  out  1  sequencer can accept a request.
REQ-010 flush  in  1  abort any in-flight operation.
REQ-011 dp_A / dp_B  out  W  operands to mult/div datapath.
REQ-012 dp_ctrl_MULT / dp_ctrl_DIV  out  1  one-cycle start pulses to datapath.
REQ-013 dp_result  in  W; dp_exception  in  1; dp_ready  in  1  datapath outputs.
REQ-014 wb_valid  out  1; wb_rd  out  5; wb_data  out  W; wb_exception  out  1  writeback port.
REQ-015 wb_accept  in  1  writeback consumer takes result.
REQ-016 stall  out  1  high whenever state != IDLE.

Function
REQ-017 FSM states: IDLE, START, RUN, DONE.
REQ-018 IDLE: req_ready=1; handshake = req_valid & req_ready; on handshake latch op, a, b, rd.
REQ-019 IDLE handshake with req_op=1 and req_b==0: go directly to DONE, wb_data=0, wb_exception=1, no datapath pulse.
REQ-020 Other IDLE handshake: go to START.
REQ-021 START (exactly one cycle): assert dp_ctrl_MULT or dp_ctrl_DIV per latched op; clear cycle counter; go to RUN.
REQ-022 dp_A/dp_B driven from latched operands continuously from START through RUN; zero in IDLE.
REQ-023 RUN: counter increments each cycle; dp_ready high -> capture dp_result, dp_exception into wb regs, go to DONE.
REQ-024 RUN: counter reaching TIMEOUT without dp_ready -> DONE with wb_data=0, wb_exception=1.
REQ-025 Latency: dp_ready in cycle N -> wb_valid=1 in cycle N+1.
REQ-026 DONE: wb_valid=1, wb_rd=latched rd; outputs held stable until wb_accept; wb_accept -> IDLE next cycle.
REQ-027 req_ready=0 in START, RUN, DONE; requests there are ignored, not queued.
REQ-028 flush in any state -> IDLE next cycle, wb_valid=0, result discarded; flush beats wb_accept and req_valid.
REQ-029 dp_ready outside RUN ignored.
REQ-030 Counter width ceil(log2(TIMEOUT+1)); saturates, never wraps.

Reset
REQ-031 reset -> IDLE; req_ready=1 next cycle; stall=0, wb_valid=0, wb_data=0, wb_rd=0, wb_exception=0, dp_ctrl_*=0, dp_A=dp_B=0, counter=0.
REQ-032 reset mid-operation (START/RUN/DONE) abandons operation; no further start pulse or writeback.
REQ-033 reset has priority over flush and all handshakes.

Structure
REQ-034 State encoding, op encoding (OP_MULT=0, OP_DIV=1) and TIMEOUT default in shared package muldiv_pkg.
REQ-035 One sub-module: muldiv_cycle_counter (clear, enable, saturating count output).

Verification
REQ-036 Divide 100/7, dp_ready modelled 32 cycles after pulse -> one dp_ctrl_DIV pulse, wb_data=14, wb_exception=0, wb_rd preserved, wb_valid one cycle after dp_ready.
REQ-037 Divide 5/0 -> no dp_ctrl pulse, wb_valid next cycle, wb_data=0, wb_exception=1.
REQ-038 Multiply 3*-4, wb_accept held low 5 cycles -> wb_data=-12 stable all 5 cycles, req_ready=0 until accept.
REQ-039 dp_ready never asserted -> wb_exception=1 exactly TIMEOUT cycles into RUN.
REQ-040 flush mid-RUN and reset mid-RUN -> IDLE next cycle, wb_valid never asserted; late dp_ready ignored.
